// File: rtl/id_ex_pipe.sv
// id_ex_pipe: ID/EX pipeline register with load-use stall and bubble insertion.
// Ports: i_clk/i_rst_n clock and async active-low reset; i_enable global step;
//   i_flush squashes the instruction entering EX; i_control..i_shamt ID stage
//   fields; o_control..o_shamt registered EX copies; o_valid marks a real
//   instruction; o_stall holds PC and IF/ID; o_bubble_count counts bubbles
//   when ID_EX_BUBBLE_COUNT_EN is defined, otherwise it is tied to zero.
module id_ex_pipe #(
    parameter int DATA_WIDTH   = 32,
    parameter int REG_ADDR     = 5,
    parameter int CONTROL_SIZE = 18
) (
    input  logic                    i_clk,
    input  logic                    i_rst_n,
    input  logic                    i_enable,
    input  logic                    i_flush,
    input  logic [CONTROL_SIZE-1:0] i_control,
    input  logic [DATA_WIDTH-1:0]   i_pc,
    input  logic [DATA_WIDTH-1:0]   i_rs_data,
    input  logic [DATA_WIDTH-1:0]   i_rt_data,
    input  logic [DATA_WIDTH-1:0]   i_imm,
    input  logic [REG_ADDR-1:0]     i_rs,
    input  logic [REG_ADDR-1:0]     i_rt,
    input  logic [REG_ADDR-1:0]     i_rd,
    input  logic [4:0]              i_shamt,
    output logic [CONTROL_SIZE-1:0] o_control,
    output logic [DATA_WIDTH-1:0]   o_pc,
    output logic [DATA_WIDTH-1:0]   o_rs_data,
    output logic [DATA_WIDTH-1:0]   o_rt_data,
    output logic [DATA_WIDTH-1:0]   o_imm,
    output logic [REG_ADDR-1:0]     o_rs,
    output logic [REG_ADDR-1:0]     o_rt,
    output logic [REG_ADDR-1:0]     o_rd,
    output logic [4:0]              o_shamt,
    output logic                    o_valid,
    output logic                    o_stall,
    output logic [31:0]             o_bubble_count
);
    logic hazard, bubble;
    // Both source fields are compared even when unused; a rare false stall is cheaper than decoding usage.
    assign hazard  = o_valid & o_control[3] & (o_rt != '0) & ((o_rt == i_rs) | (o_rt == i_rt));
    assign o_stall = hazard & ~i_flush & i_enable;
    assign bubble  = i_flush | hazard;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_control <= '0;
            o_pc      <= '0;
            o_rs_data <= '0;
            o_rt_data <= '0;
            o_imm     <= '0;
            o_rs      <= '0;
            o_rt      <= '0;
            o_rd      <= '0;
            o_shamt   <= '0;
            o_valid   <= 1'b0;
        end else if (i_enable) begin
            o_control <= bubble ? '0 : i_control;
            o_pc      <= bubble ? '0 : i_pc;
            o_rs_data <= bubble ? '0 : i_rs_data;
            o_rt_data <= bubble ? '0 : i_rt_data;
            o_imm     <= bubble ? '0 : i_imm;
            o_rs      <= bubble ? '0 : i_rs;
            o_rt      <= bubble ? '0 : i_rt;
            o_rd      <= bubble ? '0 : i_rd;
            o_shamt   <= bubble ? '0 : i_shamt;
            o_valid   <= ~bubble;
        end
    end
`ifdef ID_EX_BUBBLE_COUNT_EN
    logic [31:0] bubble_cnt;
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n)
            bubble_cnt <= '0;
        else if (i_enable && bubble && bubble_cnt != '1)
            bubble_cnt <= bubble_cnt + 32'd1;
    end
    assign o_bubble_count = bubble_cnt;
`else
    assign o_bubble_count = '0;
`endif
endmodule

// File: tb/tb_id_ex_pipe.sv
// tb_id_ex_pipe: randomized self-checking bench for id_ex_pipe against a behavioural model.
module tb_id_ex_pipe;
`ifdef ID_EX_BUBBLE_COUNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif
    localparam logic [17:0] LW   = 18'h02649;
    localparam logic [17:0] ADDU = 18'h01C85;

    logic        i_clk = 1'b0, i_rst_n = 1'b0, i_enable = 1'b1, i_flush = 1'b0;
    logic [17:0] i_control = '0;
    logic [31:0] i_pc = '0, i_rs_data = '0, i_rt_data = '0, i_imm = '0;
    logic [4:0]  i_rs = '0, i_rt = '0, i_rd = '0, i_shamt = '0;
    logic [17:0] o_control;
    logic [31:0] o_pc, o_rs_data, o_rt_data, o_imm, o_bubble_count;
    logic [4:0]  o_rs, o_rt, o_rd, o_shamt;
    logic        o_valid, o_stall;

    id_ex_pipe dut (
        .i_clk(i_clk), .i_rst_n(i_rst_n), .i_enable(i_enable), .i_flush(i_flush),
        .i_control(i_control), .i_pc(i_pc), .i_rs_data(i_rs_data), .i_rt_data(i_rt_data),
        .i_imm(i_imm), .i_rs(i_rs), .i_rt(i_rt), .i_rd(i_rd), .i_shamt(i_shamt),
        .o_control(o_control), .o_pc(o_pc), .o_rs_data(o_rs_data), .o_rt_data(o_rt_data),
        .o_imm(o_imm), .o_rs(o_rs), .o_rt(o_rt), .o_rd(o_rd), .o_shamt(o_shamt),
        .o_valid(o_valid), .o_stall(o_stall), .o_bubble_count(o_bubble_count)
    );

    always #5 i_clk = ~i_clk;

    int checks = 0, failures = 0;

    // Model of the instruction sitting in EX, as a record of what was issued.
    typedef struct packed {
        logic [17:0] ctrl;
        logic [31:0] pc, rs_data, rt_data, imm;
        logic [4:0]  rs, rt, rd, shamt;
        logic        valid;
    } ex_t;
    ex_t         m_ex = '0;
    logic [63:0] m_bubbles = 0;

    wire ex_t dut_ex = '{o_control, o_pc, o_rs_data, o_rt_data, o_imm, o_rs, o_rt, o_rd, o_shamt, o_valid};

    // A load in EX conflicts when the ID instruction names its destination as a source.
    function automatic bit load_use();
        return m_ex.valid && m_ex.ctrl[3] && m_ex.rt != 5'd0 && (m_ex.rt == i_rs || m_ex.rt == i_rt);
    endfunction
    function automatic bit exp_stall();
        return i_enable && !i_flush && load_use();
    endfunction
    function automatic logic [31:0] exp_cnt();
        if (!CNT_EN) return 32'd0;
        return m_bubbles > 64'hFFFF_FFFF ? 32'hFFFF_FFFF : m_bubbles[31:0];
    endfunction

    task automatic model_reset();
        m_ex = '0;
        m_bubbles = 0;
    endtask

    // Advance one clock edge; the model takes the inputs visible at the edge.
    task automatic step();
        @(posedge i_clk);
        if (i_enable) begin
            if (i_flush || load_use()) begin
                m_ex = '0;
                m_bubbles = m_bubbles + 1;
            end else
                m_ex = '{i_control, i_pc, i_rs_data, i_rt_data, i_imm, i_rs, i_rt, i_rd, i_shamt, 1'b1};
        end
        #1;
    endtask

    task automatic drive(input logic [17:0] c, input logic [4:0] rs, input logic [4:0] rt,
                         input logic fl, input logic en);
        i_control = c; i_rs = rs; i_rt = rt; i_rd = 5'($urandom); i_shamt = 5'($urandom);
        i_pc = $urandom; i_rs_data = $urandom; i_rt_data = $urandom; i_imm = $urandom;
        i_flush = fl; i_enable = en;
        #1;
    endtask

    task automatic test_reset();
        i_rst_n = 1'b0;
        for (int k = 0; k < 3; k++) begin
            drive(18'($urandom), 5'($urandom), 5'($urandom), 1'($urandom), 1'b1);
            @(negedge i_clk);
            checks++;
            if (dut_ex !== '0 || o_stall !== 1'b0 || o_bubble_count !== 32'd0) begin
                failures++;
                $display("FAIL reset_state got=%h stall=%b cnt=%h want all zero", dut_ex, o_stall, o_bubble_count);
            end
        end
        model_reset();
        i_rst_n = 1'b1;
        drive(ADDU, 5'd1, 5'd2, 1'b0, 1'b1);
        i_rs_data = 32'd5; i_rt_data = 32'd7;
        step();
        checks++;
        if (o_control !== ADDU || o_rs_data !== 32'd5 || o_rt_data !== 32'd7 || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_first_capture got ctrl=%h rs=%0d rt=%0d v=%b want %h 5 7 1", o_control, o_rs_data, o_rt_data, o_valid, ADDU);
        end
        checks++;
        if (dut_ex !== m_ex) begin
            failures++;
            $display("FAIL reset_first_fields got=%h want=%h", dut_ex, m_ex);
        end
    endtask

    task automatic test_load_use();
        logic [31:0] c0;
        c0 = exp_cnt();
        drive(LW, 5'd1, 5'd2, 1'b0, 1'b1);
        step();
        drive(ADDU, 5'd2, 5'd6, 1'b0, 1'b1);
        checks++;
        if (o_stall !== 1'b1) begin
            failures++;
            $display("FAIL load_use_stall got=%b want=1", o_stall);
        end
        step();
        checks++;
        if (o_control !== 18'd0 || o_valid !== 1'b0 || o_stall !== 1'b0) begin
            failures++;
            $display("FAIL load_use_bubble got ctrl=%h v=%b stall=%b want 0 0 0", o_control, o_valid, o_stall);
        end
        step();
        checks++;
        if (o_control !== ADDU || o_rs !== 5'd2 || o_valid !== 1'b1 || dut_ex !== m_ex) begin
            failures++;
            $display("FAIL load_use_release got=%h want=%h", dut_ex, m_ex);
        end
        checks++;
        if (o_bubble_count !== (CNT_EN ? c0 + 32'd1 : 32'd0)) begin
            failures++;
            $display("FAIL load_use_count got=%0d want=%0d", o_bubble_count, CNT_EN ? c0 + 32'd1 : 32'd0);
        end
    endtask

    task automatic test_no_false_stall();
        drive(LW, 5'd1, 5'd0, 1'b0, 1'b1);
        step();
        drive(ADDU, 5'd0, 5'd0, 1'b0, 1'b1);
        checks++;
        if (o_stall !== 1'b0) begin
            failures++;
            $display("FAIL no_stall_r0 got=%b want=0", o_stall);
        end
        step();
        drive(LW, 5'd1, 5'd3, 1'b0, 1'b1);
        step();
        drive(ADDU, 5'd4, 5'd5, 1'b0, 1'b1);
        checks++;
        if (o_stall !== 1'b0) begin
            failures++;
            $display("FAIL no_stall_other_reg got=%b want=0", o_stall);
        end
        step();
        checks++;
        if (o_valid !== 1'b1 || o_rs !== 5'd4 || dut_ex !== m_ex) begin
            failures++;
            $display("FAIL no_stall_capture got=%h want=%h", dut_ex, m_ex);
        end
    endtask

    task automatic test_flush_priority();
        logic [31:0] c0;
        drive(LW, 5'd1, 5'd9, 1'b0, 1'b1);
        step();
        c0 = exp_cnt();
        drive(ADDU, 5'd9, 5'd9, 1'b1, 1'b1);
        checks++;
        if (o_stall !== 1'b0) begin
            failures++;
            $display("FAIL flush_prio_stall got=%b want=0", o_stall);
        end
        step();
        checks++;
        if (dut_ex !== '0 || o_bubble_count !== (CNT_EN ? c0 + 32'd1 : 32'd0)) begin
            failures++;
            $display("FAIL flush_prio_bubble got=%h cnt=%0d want 0 cnt=%0d", dut_ex, o_bubble_count, CNT_EN ? c0 + 32'd1 : 32'd0);
        end
    endtask

    task automatic test_enable_hold();
        ex_t held;
        logic [31:0] c0;
        drive(LW, 5'd1, 5'd7, 1'b0, 1'b1);
        step();
        held = m_ex;
        c0 = exp_cnt();
        for (int k = 0; k < 3; k++) begin
            drive(18'($urandom), 5'd7, 5'($urandom), 1'b1, 1'b0);
            checks++;
            if (o_stall !== 1'b0) begin
                failures++;
                $display("FAIL enable_hold_stall got=%b want=0", o_stall);
            end
            step();
            checks++;
            if (dut_ex !== held || o_bubble_count !== c0) begin
                failures++;
                $display("FAIL enable_hold got=%h cnt=%0d want=%h cnt=%0d", dut_ex, o_bubble_count, held, c0);
            end
        end
        drive(ADDU, 5'd7, 5'd1, 1'b0, 1'b1);
        checks++;
        if (o_stall !== 1'b1) begin
            failures++;
            $display("FAIL enable_resume_stall got=%b want=1", o_stall);
        end
        step();
        step();
        checks++;
        if (o_control !== ADDU || o_valid !== 1'b1 || dut_ex !== m_ex) begin
            failures++;
            $display("FAIL enable_resume got=%h want=%h", dut_ex, m_ex);
        end
    endtask

    task automatic test_reset_mid_stall();
        drive(LW, 5'd1, 5'd4, 1'b0, 1'b1);
        step();
        drive(ADDU, 5'd3, 5'd4, 1'b0, 1'b1);
        i_rst_n = 1'b0;
        model_reset();
        #1;
        checks++;
        if (o_stall !== 1'b0 || o_valid !== 1'b0 || o_bubble_count !== 32'd0) begin
            failures++;
            $display("FAIL reset_mid_stall got stall=%b v=%b cnt=%0d want 0 0 0", o_stall, o_valid, o_bubble_count);
        end
        @(negedge i_clk);
        i_rst_n = 1'b1;
        step();
        checks++;
        if (dut_ex !== m_ex || o_valid !== 1'b1) begin
            failures++;
            $display("FAIL reset_mid_recover got=%h want=%h", dut_ex, m_ex);
        end
    endtask

    task automatic test_flush_count();
        for (int k = 0; k < 10; k++) begin
            drive(18'($urandom), 5'($urandom), 5'($urandom), 1'b1, 1'b1);
            step();
        end
        checks++;
        if (o_bubble_count !== exp_cnt() || dut_ex !== '0) begin
            failures++;
            $display("FAIL flush_count got=%0d want=%0d", o_bubble_count, exp_cnt());
        end
    endtask

    task automatic test_random();
        bit hold;
        hold = 1'b0;
        for (int k = 0; k < 400; k++) begin
            if (!hold)
                drive(($urandom_range(0, 2) == 0) ? LW : (18'($urandom) & ~18'h8),
                      5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)),
                      $urandom_range(0, 9) == 0, $urandom_range(0, 9) != 0);
            else begin
                i_flush = $urandom_range(0, 9) == 0;
                i_enable = $urandom_range(0, 9) != 0;
                #1;
            end
            hold = exp_stall();
            checks++;
            if (o_stall !== hold) begin
                failures++;
                $display("FAIL random_stall cyc=%0d got=%b want=%b", k, o_stall, hold);
            end
            step();
            checks++;
            if (dut_ex !== m_ex || o_bubble_count !== exp_cnt()) begin
                failures++;
                $display("FAIL random_ex cyc=%0d got=%h cnt=%0d want=%h cnt=%0d", k, dut_ex, o_bubble_count, m_ex, exp_cnt());
            end
        end
    endtask

    task automatic test_counter_sat();
`ifdef ID_EX_BUBBLE_COUNT_EN
        drive(ADDU, 5'd0, 5'd0, 1'b0, 1'b0);
        force dut.bubble_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.bubble_cnt;
        m_bubbles = 64'hFFFF_FFFE;
        for (int k = 0; k < 3; k++) begin
            drive(ADDU, 5'd0, 5'd0, 1'b1, 1'b1);
            step();
            checks++;
            if (o_bubble_count !== 32'hFFFF_FFFF) begin
                failures++;
                $display("FAIL counter_sat got=%h want=ffffffff", o_bubble_count);
            end
        end
`endif
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_no_false_stall();
        test_flush_priority();
        test_enable_hold();
        test_flush_count();
        test_reset_mid_stall();
        test_random();
        test_counter_sat();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
